predictor_update_controller: RTL and testbench
==============================================

# predictor_update_controller

Sequencing and bookkeeping block for the branch predictor. It holds the pattern history table of 2-bit saturating counters that supplies fetch-stage predictions. On every resolved branch it updates the matching counter. On a misprediction reported by the prediction-check logic it runs the pipeline redirect/flush sequence. It sits between the write-back branch resolution (prediction check) and the fetch/PC logic.

## Interface
Parameters:
- TABLE_BITS, 4: log2 of table entries; index = address[TABLE_BITS-1:0]
- FLUSH_CYCLES, 2: cycles `flush` stays high per misprediction; legal range 1..15
- ADDR_WIDTH, 11: instruction address width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- lookup_valid  in  1  fetch stage presents a branch
- lookup_addr  in  ADDR_WIDTH  address of the fetched branch
- predict_taken  out  1  prediction for lookup_addr
- resolve_valid  in  1  a branch resolves this cycle
- resolve_addr  in  ADDR_WIDTH  address of the resolving branch
- branch_result  in  1  actual outcome, 1 = taken
- prediction_failed  in  1  resolving branch was mispredicted
- failback_addr  in  ADDR_WIDTH  correct next PC after a misprediction
- pc_load  out  1  one-cycle strobe: load PC with pc_load_addr
- pc_load_addr  out  ADDR_WIDTH  redirect target
- flush  out  1  kill in-flight instructions in the fetch–execute stages
- busy  out  1  redirect sequence in progress; resolve inputs are ignored
- branch_count  out  16  accepted resolutions, saturating
- mispredict_count  out  16  accepted mispredictions, saturating

## Operation
- Table: 2^TABLE_BITS entries, 2 bits each.
  - 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - All entries reset to 01.
- predict_taken = lookup_valid & table[lookup_addr index][1]. This output is combinational from the registered table.
- Accepted resolve: resolve_valid=1 while state is IDLE.
  - branch_result=1 increments the indexed counter, saturating at 11.
  - branch_result=0 decrements it, saturating at 00.
  - branch_count increments, saturating at 0xFFFF.
- Resolves while busy=1 are discarded: no table update, no count, no new sequence. The branch is being flushed.
- FSM states: IDLE, REDIRECT, FLUSH.
  - IDLE → REDIRECT on an accepted resolve with prediction_failed=1.
    - failback_addr is latched into pc_load_addr.
    - mispredict_count increments, saturating.
  - REDIRECT → FLUSH when FLUSH_CYCLES > 1; REDIRECT → IDLE when FLUSH_CYCLES = 1.
  - FLUSH holds for FLUSH_CYCLES-1 cycles using an internal down-counter, then → IDLE.
- Output decode (Moore):
  - pc_load = (state == REDIRECT).
  - flush = (state != IDLE).
  - busy = (state != IDLE).
- pc_load_addr holds its last latched value outside REDIRECT.
- prediction_failed is ignored when resolve_valid=0.

## Timing
- Reset (rst_n=0 at an edge), applied at any point, including mid-sequence:
  - state IDLE.
  - pc_load=0, flush=0, busy=0.
  - pc_load_addr=0.
  - Both counts 0.
  - All table entries 01.
  - predict_taken is therefore 0 for every address after reset.
- Table update latency: written at the edge that accepts the resolve; visible on predict_taken from the next cycle.
  - Same-cycle lookup of the index being updated returns the old value.
- Mispredict accepted at edge N:
  - pc_load=1 during cycle N+1 only.
  - flush=1 during cycles N+1 .. N+FLUSH_CYCLES.
  - IDLE again (busy=0) at cycle N+FLUSH_CYCLES+1.
  - A resolve may be accepted at that cycle.
- A mispredicting resolve still updates the table and both counts at edge N.
- Back-to-back correct resolves are accepted every cycle with no bubbles.
- Counters at 0xFFFF remain 0xFFFF on a further increment.

## Test plan
- Reset, then lookup_valid=1 for each of the 16 index values → predict_taken=0; counts=0; flush=0.
- Three taken resolves at addr 0x005, then lookup 0x005 → entry 11, predict_taken=1. A fourth taken resolve keeps the entry at 11. Two not-taken resolves → entry 01, predict_taken=0.
- Mispredict at edge N with failback_addr=0x1A3 and FLUSH_CYCLES=2 → pc_load=1 in cycle N+1 with pc_load_addr=0x1A3; flush=1 in cycles N+1..N+2; busy=0 at N+3; mispredict_count=1; branch_count=1.
- resolve_valid=1 with prediction_failed=1 during the FLUSH state → no table change, counts unchanged, no restart. Sequence ends on schedule.
- Same cycle: resolve taken at 0x013 and lookup 0x003 (aliased index 3, entry 01) → predict_taken=0 that cycle, 1 the next cycle.
- rst_n=0 during REDIRECT → next cycle flush=0, pc_load=0, busy=0; counts 0; table back to 01.

Source files
------------

// File: rtl/predictor_update_controller.sv
// Branch predictor bookkeeping: pattern history table of 2-bit saturating counters,
// resolution/mispredict statistics, and the PC redirect / pipeline flush sequencer.
module predictor_update_controller #(
  parameter int TABLE_BITS   = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  predict_taken,
  input  logic                  resolve_valid,
  input  logic [ADDR_WIDTH-1:0] resolve_addr,
  input  logic                  branch_result,
  input  logic                  prediction_failed,
  input  logic [ADDR_WIDTH-1:0] failback_addr,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_load_addr,
  output logic                  flush,
  output logic                  busy,
  output logic [15:0]           branch_count,
  output logic [15:0]           mispredict_count
);

  localparam int          ENTRIES    = 1 << TABLE_BITS;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;
  // FLUSH lasts FLUSH_CYCLES-1 cycles; the counter holds the cycles left after the current one.
  localparam logic [3:0]  FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            flush_cnt_q, flush_cnt_d;
  logic [1:0]            pht_q [ENTRIES];
  logic [TABLE_BITS-1:0] lookup_idx, resolve_idx;
  logic [1:0]            entry_cur, entry_next;
  logic                  accept;
  logic                  unused_addr_bits;

  assign lookup_idx       = lookup_addr[TABLE_BITS-1:0];
  assign resolve_idx      = resolve_addr[TABLE_BITS-1:0];
  assign unused_addr_bits = ^{lookup_addr[ADDR_WIDTH-1:TABLE_BITS],
                              resolve_addr[ADDR_WIDTH-1:TABLE_BITS]};

  // Resolves arriving while the redirect sequence runs belong to flushed work.
  assign accept = resolve_valid && (state_q == IDLE);

  // Reads the registered table, so a same-cycle update is not visible yet.
  assign predict_taken = lookup_valid & pht_q[lookup_idx][1];

  assign pc_load = (state_q == REDIRECT);
  assign flush   = (state_q != IDLE);
  assign busy    = (state_q != IDLE);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    entry_cur  = pht_q[resolve_idx];
    entry_next = entry_cur;
    if (branch_result) begin
      if (entry_cur != 2'b11) entry_next = entry_cur + 2'd1;
    end else begin
      if (entry_cur != 2'b00) entry_next = entry_cur - 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && prediction_failed) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) state_d = IDLE;
        else                     flush_cnt_d = flush_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      flush_cnt_q      <= '0;
      pc_load_addr     <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      // NOTE: the table is built from flops and must come out of reset as weak-NT, so it is reset explicitly.
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (accept) begin
        pht_q[resolve_idx] <= entry_next;
        if (branch_count != CNT_MAX) branch_count <= branch_count + 16'd1;
        if (prediction_failed) begin
          pc_load_addr <= failback_addr;
          if (mispredict_count != CNT_MAX) mispredict_count <= mispredict_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_predictor_update_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_predictor_update_controller;

  localparam int TB_BITS = 4;
  localparam int FC      = 2;
  localparam int AW      = 11;
  localparam int N_ENT   = 1 << TB_BITS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lookup_valid;
  logic [AW-1:0] lookup_addr;
  logic          predict_taken;
  logic          resolve_valid;
  logic [AW-1:0] resolve_addr;
  logic          branch_result;
  logic          prediction_failed;
  logic [AW-1:0] failback_addr;
  logic          pc_load;
  logic [AW-1:0] pc_load_addr;
  logic          flush;
  logic          busy;
  logic [15:0]   branch_count;
  logic [15:0]   mispredict_count;

  predictor_update_controller #(
    .TABLE_BITS  (TB_BITS),
    .FLUSH_CYCLES(FC),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lookup_valid     (lookup_valid),
    .lookup_addr      (lookup_addr),
    .predict_taken    (predict_taken),
    .resolve_valid    (resolve_valid),
    .resolve_addr     (resolve_addr),
    .branch_result    (branch_result),
    .prediction_failed(prediction_failed),
    .failback_addr    (failback_addr),
    .pc_load          (pc_load),
    .pc_load_addr     (pc_load_addr),
    .flush            (flush),
    .busy             (busy),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: counter values as integers 0..3, busy time as cycles remaining.
  int            m_ent [N_ENT];
  int            m_bc, m_mc;
  int            m_busy_left;
  logic [AW-1:0] m_pla;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_ENT; i++) m_ent[i] = 1;
    m_bc = 0; m_mc = 0; m_busy_left = 0; m_pla = '0;
  endfunction

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic lv, input logic [AW-1:0] la,
                      input logic rv, input logic [AW-1:0] ra, input logic br,
                      input logic pf, input logic [AW-1:0] fa, input logic rn);
    int li, ri;
    @(negedge clk);
    lookup_valid = lv; lookup_addr = la;
    resolve_valid = rv; resolve_addr = ra; branch_result = br;
    prediction_failed = pf; failback_addr = fa; rst_n = rn;
    #1;
    li = int'(la) % N_ENT;
    ri = int'(ra) % N_ENT;
    check("predict_taken",    32'(predict_taken),    32'(lv && (m_ent[li] >= 2)));
    check("pc_load",          32'(pc_load),          32'(m_busy_left == FC));
    check("flush",            32'(flush),            32'(m_busy_left > 0));
    check("busy",             32'(busy),             32'(m_busy_left > 0));
    check("pc_load_addr",     32'(pc_load_addr),     32'(m_pla));
    check("branch_count",     32'(branch_count),     32'(m_bc));
    check("mispredict_count", 32'(mispredict_count), 32'(m_mc));
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (rv) begin
      if (br) m_ent[ri] = (m_ent[ri] < 3) ? m_ent[ri] + 1 : 3;
      else    m_ent[ri] = (m_ent[ri] > 0) ? m_ent[ri] - 1 : 0;
      if (m_bc < 65535) m_bc++;
      if (pf) begin
        if (m_mc < 65535) m_mc++;
        m_pla = fa;
        m_busy_left = FC;
      end
    end
  endtask

  task automatic idle_cycle(input logic lv, input logic [AW-1:0] la);
    step(lv, la, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic resolve(input logic [AW-1:0] ra, input logic br, input logic pf, input logic [AW-1:0] fa);
    step(1'b0, '0, 1'b1, ra, br, pf, fa, 1'b1);
  endtask

  task automatic sweep_lookups();
    for (int i = 0; i < N_ENT; i++) idle_cycle(1'b1, AW'(i));
  endtask

  initial begin
    rst_n = 1'b0; lookup_valid = 1'b0; lookup_addr = '0;
    resolve_valid = 1'b0; resolve_addr = '0; branch_result = 1'b0;
    prediction_failed = 1'b0; failback_addr = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state: every index predicts not-taken, counts zero.
    sweep_lookups();

    // Counter saturation up, then back down to weak-NT.
    repeat (3) resolve(11'h005, 1'b1, 1'b0, '0);
    idle_cycle(1'b1, 11'h005);
    check("sat_taken_entry", 32'(m_ent[5]), 32'd3);
    resolve(11'h005, 1'b1, 1'b0, '0);
    idle_cycle(1'b1, 11'h005);
    repeat (2) resolve(11'h005, 1'b0, 1'b0, '0);
    idle_cycle(1'b1, 11'h005);
    check("down_to_weak_nt", 32'(m_ent[5]), 32'd1);

    // Mispredict with redirect, then a resolve inside FLUSH that must be ignored.
    resolve(11'h040, 1'b0, 1'b1, 11'h1A3);
    idle_cycle(1'b0, '0);
    step(1'b1, 11'h040, 1'b1, 11'h040, 1'b1, 1'b1, 11'h2FF, 1'b1);
    idle_cycle(1'b1, 11'h040);
    check("failback_latched", 32'(m_pla), 32'h1A3);

    // Same-cycle lookup of an aliased index being updated sees the old entry.
    step(1'b1, 11'h003, 1'b1, 11'h013, 1'b1, 1'b0, '0, 1'b1);
    idle_cycle(1'b1, 11'h003);

    // Reset while REDIRECT is active.
    resolve(11'h00A, 1'b1, 1'b1, 11'h055);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    idle_cycle(1'b0, '0);
    sweep_lookups();

    // Random traffic with occasional mid-run resets.
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom),
           1'($urandom_range(0, 99) < 60), AW'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 15), AW'($urandom),
           1'($urandom_range(0, 199) != 0));
    end
    idle_cycle(1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
